// File: rtl/bpsk_pkg.sv
// Shared constants and sizing helpers for the BPSK carrier-selection stage.
package bpsk_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_MOD   = 2'd2;

  function automatic int samples_per_bit(input int sample_number, input int periods_per_bit);
    return sample_number * periods_per_bit;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bpsk_modulator_serializer.sv
// Word shift register and bit counter; presents the current symbol bit MSB first.
module bpsk_serializer
  import bpsk_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  msb,
  output logic                  last_bit
);

  localparam int BIT_W = cnt_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shreg_r;
  logic [BIT_W-1:0]      bit_cnt_r;

  // Load has priority so a back-to-back word replaces the finished one.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      shreg_r   <= '0;
      bit_cnt_r <= '0;
    end else if (load) begin
      shreg_r   <= data;
      bit_cnt_r <= '0;
    end else if (shift) begin
      shreg_r   <= shreg_r << 1;
      bit_cnt_r <= bit_cnt_r + BIT_W'(1);
    end else begin
      shreg_r   <= shreg_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  assign msb      = shreg_r[DATA_WIDTH-1];
  assign last_bit = (bit_cnt_r == BIT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK carrier selector: serializes accepted words and picks sin or -sin per bit,
// with every symbol starting on a carrier period boundary.
module bpsk_modulator
  import bpsk_pkg::*;
#(
  parameter int SAMPLE_NUMBER   = 256,
  parameter int SAMPLE_WIDTH    = 12,
  parameter int PERIODS_PER_BIT = 1,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                             clk,
  input  logic                             arstn,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic                             gen_en,
  input  logic [SAMPLE_WIDTH-1:0]          sin_in,
  input  logic [SAMPLE_WIDTH-1:0]          neg_sin_in,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
  output logic [SAMPLE_WIDTH-1:0]          mod_out,
  output logic                             mod_valid,
  output logic                             busy
);

  localparam int CNT_W  = $clog2(SAMPLE_NUMBER);
  localparam int SPB    = samples_per_bit(SAMPLE_NUMBER, PERIODS_PER_BIT);
  localparam int SAMP_W = cnt_width(SPB);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SPB - 1);

  logic [1:0]              state_r, state_nx;
  logic [SAMP_W-1:0]       samp_cnt_r, samp_nx, cur_samp_s;
  logic                    gen_en_r, gen_ok_r;
  logic [SAMPLE_WIDTH-1:0] mod_out_r;
  logic                    mod_valid_r, busy_r;
  logic                    boundary_s, emit_s, load_s, shift_s, s_ready_s;
  logic                    msb_s, last_bit_s;

  bpsk_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (clk),
    .arstn    (arstn),
    .load     (load_s),
    .shift    (shift_s),
    .data     (s_data),
    .msb      (msb_s),
    .last_bit (last_bit_s)
  );

  // sin_in lags the generator counter by one, so cnt_in==1 means sample 0 is present.
  assign boundary_s = gen_ok_r && (cnt_in == CNT_W'(1));

  // Next-state, counter and handshake decode; emit_s marks a cycle that captures a sample.
  always_comb begin
    state_nx   = state_r;
    samp_nx    = samp_cnt_r;
    cur_samp_s = '0;
    emit_s     = 1'b0;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    s_ready_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        s_ready_s = gen_en_r;
        if (s_valid && gen_en_r) begin
          load_s   = 1'b1;
          samp_nx  = '0;
          state_nx = ST_ALIGN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (boundary_s) begin
          emit_s = 1'b1;
        end else begin
          emit_s = 1'b0;
        end
      end
      ST_MOD: begin
        emit_s     = 1'b1;
        cur_samp_s = samp_cnt_r;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    if (emit_s) begin
      state_nx = ST_MOD;
      if (cur_samp_s == SAMP_LAST) begin
        samp_nx = '0;
        if (last_bit_s) begin
          s_ready_s = 1'b1;
          if (s_valid) begin
            load_s = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          shift_s = 1'b1;
        end
      end else begin
        samp_nx = cur_samp_s + SAMP_W'(1);
      end
    end else begin
      shift_s = 1'b0;
    end
  end

  // Generator enable rises once after reset and is never dropped.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      gen_en_r <= 1'b0;
      gen_ok_r <= 1'b0;
    end else begin
      gen_en_r <= 1'b1;
      gen_ok_r <= gen_en_r;
    end
  end

  // FSM, sample counter and registered sample output.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r     <= ST_IDLE;
      samp_cnt_r  <= '0;
      mod_out_r   <= '0;
      mod_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      samp_cnt_r  <= samp_nx;
      mod_out_r   <= emit_s ? (msb_s ? sin_in : neg_sin_in) : '0;
      mod_valid_r <= emit_s;
      busy_r      <= (state_nx != ST_IDLE);
    end
  end

  assign s_ready   = s_ready_s;
  assign gen_en    = gen_en_r;
  assign mod_out   = mod_out_r;
  assign mod_valid = mod_valid_r;
  assign busy      = busy_r;

endmodule

// File: doc/bpsk_modulator.md
Name: bpsk_modulator

Overview:
- Carrier-selection stage directly downstream of the BPSK sine generator.
- Accepts bytes over a valid/ready handshake and serializes them MSB first.
- Each bit is mapped to carrier phase: bit 1 selects sin_in, bit 0 selects neg_sin_in.
- Every bit occupies PERIODS_PER_BIT whole carrier periods, starting on a carrier period boundary; drives the generator enable and emits the modulated sample stream to the DAC/channel stage.

Parameters:
SAMPLE_NUMBER, 256, samples per carrier period; must match the generator.
SAMPLE_WIDTH, 12, carrier sample width.
PERIODS_PER_BIT, 1, carrier periods per symbol (≥1).
DATA_WIDTH, 8, bits per accepted word.

Ports:
clk  in  1  system clock
arstn  in  1  asynchronous active-low reset
s_data  in  DATA_WIDTH  word to transmit
s_valid  in  1  s_data valid
s_ready  out  1  word accepted when s_valid & s_ready at posedge
gen_en  out  1  enable to sine generator
sin_in  in  SAMPLE_WIDTH  generator sin sample
neg_sin_in  in  SAMPLE_WIDTH  generator negated sin sample
cnt_in  in  $clog2(SAMPLE_NUMBER)  generator phase counter
mod_out  out  SAMPLE_WIDTH  modulated sample
mod_valid  out  1  mod_out carries a symbol sample
busy  out  1  FSM not in IDLE

Behaviour:
Decided interface:
- Reset arstn, asynchronous, active-low; clock clk.
- All outputs reset to 0: gen_en, s_ready, mod_out, mod_valid, busy. State resets to IDLE.

Generator control:
- gen_en is registered: 0 in reset, then 1 from the first clk edge after reset release, and held high permanently.
- gen_en is never dropped, because the generator tri-states its sample outputs when disabled.
- gen_ok sets one cycle after gen_en rises and stays set; this marks the generator samples as valid.

Phase:
- The generator registers rom[cnt] while advancing cnt, so sin_in holds sample index (cnt_in−1) mod SAMPLE_NUMBER.
- boundary = gen_ok & (cnt_in == 1), meaning sin_in holds sample 0 this cycle.

FSM:
- IDLE:
  - s_ready=1, mod_valid=0, mod_out=0.
  - On s_valid: capture s_data into the shift register, clear bit_cnt and samp_cnt, go to ALIGN.
- ALIGN:
  - s_ready=0.
  - Wait for boundary. On the boundary cycle, go to MOD and capture the first sample of bit MSB.
  - If boundary coincides with the first ALIGN cycle, the sample is still captured that cycle.
- MOD, each cycle:
  - mod_out <= shreg[MSB] ? sin_in : neg_sin_in; mod_valid <= 1.
  - samp_cnt counts 0 .. SAMPLE_NUMBER*PERIODS_PER_BIT−1.
  - At samp_cnt wrap: shift left, bit_cnt++.
- Last sample of last bit (bit_cnt==DATA_WIDTH−1 and samp_cnt at max):
  - s_ready=1 combinationally for that cycle.
  - If s_valid: load the new word, clear counters, stay in MOD. The next cycle is sample 0 of the new word's MSB, with no gap and continuous phase.
  - Else: go to IDLE. mod_valid drops and mod_out returns to 0 the cycle after the last captured sample is presented.

Latency and alignment:
- mod_out is one register after sin_in/neg_sin_in, so mod_out shows sample k one cycle after sin_in showed sample k.
- The symbol's sample 0 appears on mod_out the cycle after boundary.
- Symbol edges always coincide with carrier sample index 0; phase flips only at those edges.

Width rules:
- samp_cnt width is $clog2(SAMPLE_NUMBER*PERIODS_PER_BIT).
- bit_cnt width is $clog2(DATA_WIDTH), minimum 1.
- Samples pass through unmodified; no arithmetic on sample data.

Boundary conditions:
- s_valid outside IDLE and outside the last-sample cycle: ignored, word not consumed.
- s_data changing after acceptance: no effect.
- Reset mid-word: immediate return to IDLE; partial word discarded; gen_en drops to 0 and restarts after release.
- PERIODS_PER_BIT=1 with SAMPLE_NUMBER=2: same rules apply, with boundary on cnt_in==1.

Decomposition:
- bpsk_pkg holds:
  - state enum (IDLE, ALIGN, MOD)
  - localparam function for SAMPLES_PER_BIT = SAMPLE_NUMBER*PERIODS_PER_BIT
  - counter width helpers
- Sub-module bpsk_serializer: shift register + bit counter, with load/shift/last_bit outputs.
- The FSM, sample counter and output mux stay in bpsk_modulator.

Test Plan:
1. Reset release, no traffic -> gen_en=1 one cycle after release; mod_valid=0, mod_out=0, s_ready=1, busy=0 indefinitely.
2. Single word 0xA5 (defaults) -> first mod_valid the cycle after cnt_in==1; 2048 valid samples; mod_out equals sin for bits 1,0,1,0,0,1,0,1 order-mapped (1→sin, 0→neg_sin), checked against the ROM per sample; then mod_valid=0.
3. Back-to-back 0xFF then 0x00 held valid -> second accepted on the last sample of the first; 4096 contiguous valid samples; polarity flips exactly at sample 2048 at ROM index 0.
4. Word presented when cnt_in==5 -> ALIGN waits until cnt_in==1; first valid mod_out is rom[0]; no partial-period output.
5. PERIODS_PER_BIT=3, DATA_WIDTH=4, word 0x6 -> bits 0,1,1,0; 768 samples per bit; 3072 total.
6. arstn asserted mid-bit 3 -> next cycle: all outputs 0, busy=0. After release, a new word 0x81 transmits fully and correctly with no remnant of the old word.
